// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types and default bus widths
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_mst_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int cand;

    // First set bit at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by NUM_REQ requesters
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    apb_mst_state_t     state, state_next;
    logic [IDX_W-1:0]   rr_ptr, winner;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout_hit;
    logic               complete;

    // The requester just completed still holds req during its done cycle; mask it
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req & ~done),
        .ptr   (rr_ptr),
        .grant (gnt_vec),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    assign timeout_hit = !pready && (cnt == CNT_W'(TIMEOUT - 1));
    assign complete    = (state == APB_ACCESS) && (pready || timeout_hit);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= APB_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            APB_IDLE:   if (gnt_valid) state_next = APB_SETUP;
            APB_SETUP:  state_next = APB_ACCESS;
            APB_ACCESS: if (complete) state_next = APB_IDLE;
            default:    state_next = APB_IDLE;
        endcase
    end

    always_comb begin
        psel    = (state != APB_IDLE);
        penable = (state == APB_ACCESS);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            winner    <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                APB_IDLE: begin
                    if (gnt_valid) begin
                        winner <= gnt_idx;
                        pwrite <= req_write[gnt_idx];
                        paddr  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                        pwdata <= req_wdata[gnt_idx*DATA_W +: DATA_W];
                    end
                end
                APB_SETUP: cnt <= '0;
                APB_ACCESS: begin
                    if (complete) begin
                        for (int i = 0; i < NUM_REQ; i++)
                            done[i] <= (winner == IDX_W'(i));
                        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                        rsp_err   <= pready ? pslverr : 1'b1;
                        rr_ptr    <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Round-robin APB master that shares the single APB RAM slave among NUM_REQ local requesters. Each requester presents a simple request/done interface. The block grants one requester at a time and runs a full APB SETUP→ACCESS transfer on its behalf. It returns read data or error to that requester and adds a timeout so a silent slave cannot hang the bus. It sits between the local requesters (DMA, CPU shim, test engine) and the APB slave port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort (≥2)

Ports:
pclk  in  1  APB clock
presetn  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  per-requester transfer request; held high with fields stable until done
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
done  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
rsp_rdata  out  DATA_W  read data, valid in the done cycle
rsp_err  out  1  pslverr or timeout, valid in the done cycle
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset (presetn=0, asynchronous): state=IDLE; psel=penable=pwrite=0; paddr=pwdata=0; done=0; rsp_rdata=0; rsp_err=0; rr pointer=0; timeout counter=0. Assertion mid-transfer aborts it at once with no done pulse. After release the block starts from IDLE.
- All outputs are registered. Requests are sampled on posedge pclk.
- States: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0. If any req is set, pick the winner by round-robin. Search starts at index rr_ptr and wraps modulo NUM_REQ; lowest index from rr_ptr wins. Latch the winner's index, req_write, req_addr and req_wdata into paddr/pwrite/pwdata. Next state SETUP, with psel=1 and penable=0 visible in that cycle.
- SETUP: exactly one cycle. Next state ACCESS with penable=1. Clear the timeout counter.
- ACCESS: psel=1, penable=1, address/data/direction held stable.
  - pready=1: set done[winner]=1 for the following cycle. rsp_rdata=prdata on a read (0 on a write). rsp_err=pslverr. rr_ptr=winner+1 mod NUM_REQ. Next state IDLE with psel=0 and penable=0.
  - pready=0 and counter==TIMEOUT-1: same completion path, with rsp_err=1 and rsp_rdata=0.
  - Otherwise increment the counter.
- Minimum transfer is 3 cycles: IDLE-grant, SETUP, ACCESS with pready=1. done rises in the cycle the block re-enters IDLE.
- The bus always has at least one IDLE cycle (psel=0) between transfers. This is required so the slave passes through its idle/setup qualification.
- Latched transfer fields ignore any change on req_* after the grant. Dropping req mid-transfer does not abort; done is still pulsed.
- A requester that holds req high in the cycle after its done is treated as a new request.
- Only one done bit is ever set. done and rsp_* are zero/held outside completion. rsp_rdata and rsp_err are only guaranteed in the done cycle.
- When all requesters assert together, grants rotate 0,1,2,3,0,… (starvation-free).
- The timeout counter width is $clog2(TIMEOUT)+1. It does not wrap.

Decomposition:
- Package apb_pkg:
  - typedef enum {APB_IDLE, APB_SETUP, APB_ACCESS} apb_mst_state_t
  - localparams for default ADDR_W/DATA_W shared with the slave
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin grant from req and rr_ptr, outputting a one-hot grant and a binary index. The top-level FSM and registers stay in apb_master_arbiter.

Test Plan:
- Single write: req[0]=1, write, addr=5, wdata=0xDEADBEEF → psel rises in cycle 1, penable in cycle 2, slave pready → done[0] pulse, rsp_err=0. A following read of addr 5 by req[1] returns rsp_rdata=0xDEADBEEF.
- Round-robin: req=4'b1111 held continuously → done order 0,1,2,3,0, with psel low for ≥1 cycle between each transfer.
- Slave error: read addr=40 (≥32) → done pulse with rsp_err=1, and the block returns to IDLE.
- Timeout: slave model holds pready=0 → abort after exactly 16 ACCESS cycles, with rsp_err=1, rsp_rdata=0 and psel deasserted next cycle.
- Reset mid-ACCESS: presetn pulled low while penable=1 → psel/penable/done go 0 asynchronously. After release, a pending req[2] is granted first, since rr_ptr=0 and req[0]/req[1] are low.
- Field stability: change req_addr[0] from 3 to 7 after the grant → paddr stays 3 through ACCESS.
